iterative_alu: RTL and testbench

- Execution-stage ALU that consumes the 4-bit ALU selection code produced by the ALU control decoder, together with the two operands from the register file / immediate mux.
- Non-shift operations complete in one registered cycle.
- Shifts (SLL, SRL, SRA) run iteratively, one bit per cycle, to save area on the small core.
- A start/busy/done handshake lets the pipeline controller stall fetch/decode while a shift is in flight.

---
 rtl/iterative_alu.sv | 188 ++++++++++++++++++
 tb/tb_iterative_alu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Purpose: execution-stage ALU; single-cycle logic/arith, bit-serial SLL/SRL/SRA.
// Latency: done in cycle start+1, or start+1+shamt for shifts with shamt>0.
// Backpressure: busy=1 while shifting; start is ignored (not queued) while busy.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 operation request, sampled only when busy=0
//   alu_sel               ALU_* operation code from the ALU control decoder
//   a, b                  operands; b[SHAMT_W-1:0] is the shift amount
//   busy, done            in-flight indicator, one-cycle completion pulse
//   result                registered result, held until the next done
//   zero/carry/overflow/sign  flags for the registered result
module iterative_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         alu_sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               carry,
  output logic               overflow,
  output logic               sign
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   sh_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               accept;
  logic               start_shift;
  logic               finish_single;
  logic               last_step;
  logic [WIDTH-1:0]   sh_step;

  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_sub;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  assign shamt    = b[SHAMT_W-1:0];
  assign is_shift = (alu_sel == ALU_SLL) || (alu_sel == ALU_SRL) || (alu_sel == ALU_SRA);

  // Requests are only taken when no shift is in flight (IDLE or DONE).
  assign accept        = start && (state != SHIFT);
  assign start_shift   = accept && is_shift && (shamt != '0);
  assign finish_single = accept && !start_shift;
  assign last_step     = (state == SHIFT) && (cnt_q == SHAMT_W'(1));

  // One bit of the serial shifter; SRA replicates the current MSB.
  always_comb begin
    sh_step = sh_q;
    case (op_q)
      ALU_SLL: sh_step = {sh_q[WIDTH-2:0], 1'b0};
      ALU_SRL: sh_step = {1'b0, sh_q[WIDTH-1:1]};
      default: sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
  end

  // Single-cycle path works on the inputs in the start cycle, which is the
  // same data that gets latched on that edge.
  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = b;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_c   = sum_add[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_c   = sum_sub[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_XOR:  alu_res = a ^ b;
      ALU_OR:   alu_res = a | b;
      ALU_AND:  alu_res = a & b;
      // Only reached with shamt == 0: the operand passes through unshifted.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = a;
      ALU_PASS: alu_res = b;
      default:  alu_res = b;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = start_shift ? SHIFT : DONE;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, serial shifter, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      sign     <= 1'b0;
    end else begin
      if (accept) op_q <= alu_sel;
      if (start_shift) begin
        sh_q  <= a;
        cnt_q <= shamt;
      end else if (state == SHIFT) begin
        sh_q  <= sh_step;
        cnt_q <= cnt_q - SHAMT_W'(1);
        if (last_step) begin
          result   <= sh_step;
          zero     <= (sh_step == '0);
          carry    <= 1'b0;
          overflow <= 1'b0;
          sign     <= sh_step[WIDTH-1];
        end
      end else if (finish_single) begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        carry    <= alu_c;
        overflow <= alu_v;
        sign     <= alu_res[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Purpose: self-checking bench for iterative_alu against a behavioural model.
// Latency: checks done timing per operation (start+1, start+1+shamt).
// Backpressure: checks start is ignored while busy and back-to-back issue.
module tb_iterative_alu;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SLL  = 4'b0001;
  localparam logic [3:0] SLT  = 4'b0010;
  localparam logic [3:0] SLTU = 4'b0011;
  localparam logic [3:0] XOR_ = 4'b0100;
  localparam logic [3:0] SRL  = 4'b0101;
  localparam logic [3:0] OR_  = 4'b0110;
  localparam logic [3:0] AND_ = 4'b0111;
  localparam logic [3:0] SUB  = 4'b1000;
  localparam logic [3:0] SRA  = 4'b1101;
  localparam logic [3:0] PASS = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_sel = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zero, carry, overflow, sign;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  iterative_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_sel(alu_sel), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .sign(sign)
  );

  always #5 clk = ~clk;

  // Reference: {result, zero, carry, overflow, sign} from plain arithmetic.
  function automatic logic [35:0] model(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        c, v;
    longint      sx, sy, t;
    int          n;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    n  = int'(y[4:0]);
    c  = 1'b0;
    v  = 1'b0;
    case (sel)
      ADD: begin
        r = x + y;
        c = (longint'(x) + longint'(y)) > 64'sd4294967295;
        t = sx + sy;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      SUB: begin
        r = x - y;
        c = (x >= y);
        t = sx - sy;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      SLL:  r = x << n;
      SRL:  r = x >> n;
      SRA:  r = 32'($signed(x) >>> n);
      SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
      SLTU: r = (x < y) ? 32'd1 : 32'd0;
      XOR_: r = x ^ y;
      OR_:  r = x | y;
      AND_: r = x & y;
      default: r = y;
    endcase
    return {r, (r == 32'd0), c, v, r[31]};
  endfunction

  function automatic int exp_lat(input logic [3:0] sel, input logic [31:0] y);
    if ((sel == SLL || sel == SRL || sel == SRA) && y[4:0] != 5'd0) return 1 + int'(y[4:0]);
    return 1;
  endfunction

  // Drives one request and waits (bounded) for done; lat=-1 on timeout.
  task automatic run_op(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y,
                        output logic [35:0] obs, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; alu_sel = sel; a = x; b = y;
    @(negedge clk);
    start = 1'b0; alu_sel = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    obs = {result, zero, carry, overflow, sign};
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, result, zero, carry, overflow, sign} !== 38'd0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", {busy, done, result, zero, carry, overflow, sign});
    end
  endtask

  task automatic test_add_overflow();
    logic [35:0] obs; int lat, bn;
    run_op(ADD, 32'h7FFF_FFFF, 32'd1, obs, lat, bn);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d want=1", lat); end
    checks++;
    if (obs !== {32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL add_ovf got=%h want=%h", obs, {32'h8000_0000, 4'b0011});
    end
  endtask

  task automatic test_sub();
    logic [35:0] obs; int lat, bn;
    run_op(SUB, 32'd5, 32'd5, obs, lat, bn);
    checks++;
    if (obs !== {32'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sub_equal got=%h want=%h", obs, {32'd0, 4'b1100});
    end
    run_op(SUB, 32'd3, 32'd5, obs, lat, bn);
    checks++;
    if (obs !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL sub_less got=%h want=%h", obs, {32'hFFFF_FFFE, 4'b0001});
    end
  endtask

  task automatic test_shift_long();
    logic [35:0] obs; int lat, bn;
    run_op(SRA, 32'h8000_0000, 32'd31, obs, lat, bn);
    checks++;
    if (lat !== 32 || bn !== 31) begin
      failures++; $display("FAIL sra_timing lat=%0d busy=%0d want lat=32 busy=31", lat, bn);
    end
    checks++;
    if (obs !== {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL sra_result got=%h want=%h", obs, {32'hFFFF_FFFF, 4'b0001});
    end
    run_op(SRL, 32'h8000_0000, 32'd31, obs, lat, bn);
    checks++;
    if (obs !== {32'h0000_0001, 4'b0000} || lat !== 32) begin
      failures++; $display("FAIL srl_result got=%h lat=%0d want=%h lat=32", obs, lat, {32'd1, 4'b0000});
    end
  endtask

  task automatic test_shamt_zero_and_ignore();
    logic [35:0] obs; int lat, bn, ndone;
    logic [31:0] res_at_done;
    run_op(SLL, 32'd1, 32'h20, obs, lat, bn);
    checks++;
    if (lat !== 1 || obs !== {32'd1, 4'b0000}) begin
      failures++; $display("FAIL sll_shamt0 got=%h lat=%0d want=%h lat=1", obs, lat, {32'd1, 4'b0000});
    end
    // Second start pulsed while the shift is in flight must be dropped.
    @(negedge clk);
    start = 1'b1; alu_sel = SLL; a = 32'h0000_0003; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; alu_sel = ADD; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    res_at_done = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin ndone++; res_at_done = result; end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || res_at_done !== 32'h30) begin
      failures++; $display("FAIL busy_ignore dones=%0d result=%h want dones=1 result=30", ndone, res_at_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1;
    logic        d1;
    @(negedge clk);
    start = 1'b1; alu_sel = SLT; a = 32'hFFFF_FFFF; b = 32'd1;
    @(negedge clk);
    d1 = done; r1 = result;
    start = 1'b1; alu_sel = SLTU; a = 32'hFFFF_FFFF; b = 32'd1;
    checks++;
    if (d1 !== 1'b1 || r1 !== 32'd1) begin
      failures++; $display("FAIL b2b_first done=%b result=%h want done=1 result=1", d1, r1);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
      failures++; $display("FAIL b2b_second done=%b result=%h zero=%b want done=1 result=0 zero=1", done, result, zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL b2b_pulse_width done=%b want=0", done); end
  endtask

  task automatic test_reset_mid_shift();
    logic [35:0] obs; int lat, bn, ndone;
    @(negedge clk);
    start = 1'b1; alu_sel = SLL; a = 32'd1; b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, result, zero, carry, overflow, sign} !== 38'd0) begin
      failures++; $display("FAIL reset_mid_shift got=%h want=0", {busy, done, result, zero, carry, overflow, sign});
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL reset_no_done dones=%0d want=0", ndone); end
    run_op(ADD, 32'd2, 32'd3, obs, lat, bn);
    checks++;
    if (obs !== {32'd5, 4'b0000} || lat !== 1) begin
      failures++; $display("FAIL add_after_reset got=%h lat=%0d want=%h lat=1", obs, lat, {32'd5, 4'b0000});
    end
  endtask

  task automatic test_random();
    logic [3:0]  codes [11] = '{ADD, SUB, SLL, SLT, SLTU, XOR_, SRL, SRA, OR_, AND_, PASS};
    logic [35:0] obs, expv;
    logic [3:0]  sel;
    logic [31:0] x, y;
    int lat, bn;
    for (int i = 0; i < 80; i++) begin
      sel = ($urandom_range(0, 9) == 0) ? 4'($urandom) : codes[$urandom_range(0, 10)];
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = {27'($urandom), 5'($urandom_range(0, 3))};
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) x = {~x[31], x[30:0]};
      run_op(sel, x, y, obs, lat, bn);
      expv = model(sel, x, y);
      checks++;
      if (obs !== expv || lat !== exp_lat(sel, y)) begin
        failures++;
        $display("FAIL random[%0d] sel=%h a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, sel, x, y, obs, lat, expv, exp_lat(sel, y));
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_add_overflow();
    test_sub();
    test_shift_long();
    test_shamt_zero_and_ignore();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
